// File: rtl/serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial N-bit subtractor. It computes diff = a - b - bor_in one bit per
// clock, LSB first, using one full-subtractor cell and a borrow flop. A small
// three-state FSM (IDLE -> RUN -> DONE) sequences each operation behind a
// start/ready/done handshake.
//
// Parameters:
//   WIDTH    operand/result width in bits (1..64)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request; operands are accepted on an edge with start=1 and ready=1
//   a        minuend, sampled only at accept
//   b        subtrahend, sampled only at accept
//   bor_in   initial borrow, sampled only at accept
//   ready    high only while idle
//   busy     high while running or presenting the result
//   done     one-cycle pulse; diff/bor_out are valid
//   diff     registered difference (modulo 2^WIDTH)
//   bor_out  registered final borrow (1 iff a < b + bor_in, unsigned)
//   ovf      registered signed-overflow flag (only with SERIAL_SUB_OVF_EN)
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and the two operand sign-bit flops
//                      that feed it. Without it the block has no ovf port.
// -----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bor_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter needs to reach WIDTH-1; keep at least one bit so WIDTH=1 works.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d_bit;
  logic             nb;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-subtractor cell working on the current LSBs of the operand shifters.
  assign d_bit = a_sh[0] ^ b_sh[0] ^ brw;
  assign nb    = (~a_sh[0] & b_sh[0]) | (brw & ~(a_sh[0] ^ b_sh[0]));
  assign last  = (cnt == CNT_LAST);

  // Each new difference bit enters at the MSB, so after WIDTH shifts the
  // first (LSB) bit has travelled down to bit 0. Written with shifts rather
  // than a concatenation so WIDTH=1 needs no special case.
  assign res_next = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. DONE always falls back to IDLE, so a
  // start held high is accepted once every WIDTH+2 cycles.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured only at accept, so the inputs may move
  // freely afterwards. diff/bor_out only change on the final RUN edge, which
  // keeps the previous result stable while the next one is being computed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      cnt     <= '0;
      brw     <= 1'b0;
      diff    <= '0;
      bor_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bor_in;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= nb;
          cnt  <= cnt + CW'(1);
          res  <= res_next;
          if (last) begin
            diff    <= res_next;
            bor_out <= nb;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: operand signs differ and the result sign
            // disagrees with the minuend.
            ovf     <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
